instr_fetch_stage: RTL and testbench

- Upstream neighbour of the opcode decoder.
- Owns the program counter and issues requests to instruction memory over a variable-latency request/valid handshake.
- Holds the returned instruction in an IF/ID register with a one-entry skid buffer.
- Presents instr_op (bits 31:26) to the control unit. Supports downstream stall and branch/jump redirect with flush.

---
 rtl/instr_fetch_stage.sv | 128 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC owner, imem request/valid handshake, IF/ID register with one-entry skid
// Optional performance counters are compiled in with FETCH_PERF_EN.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  instr_op
`ifdef FETCH_PERF_EN
  , output logic [PERF_W-1:0] perf_fetches
  , output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_plus4;
  logic [31:0] skid_instr, skid_instr_n, skid_pc4, skid_pc4_n;
  logic [31:0] if_instr_n, if_pc4_n;
  logic        if_valid_n;

  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;
  assign instr_op  = if_instr[31:26];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
      skid_instr  <= '0;
      skid_pc4    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_valid    <= if_valid_n;
      if_instr    <= if_instr_n;
      if_pc_plus4 <= if_pc4_n;
      skid_instr  <= skid_instr_n;
      skid_pc4    <= skid_pc4_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    if_valid_n   = if_valid;
    if_instr_n   = if_instr;
    if_pc4_n     = if_pc_plus4;
    skid_instr_n = skid_instr;
    skid_pc4_n   = skid_pc4;
    if (redirect) begin
      // Any response still owed by memory must be swallowed before refetching.
      pc_n         = redirect_pc;
      if_valid_n   = 1'b0;
      if_instr_n   = '0;
      if_pc4_n     = '0;
      skid_instr_n = '0;
      skid_pc4_n   = '0;
      state_n      = ((state != HOLD) && !imem_valid) ? DRAIN : FETCH;
    end else begin
      if (if_valid && !stall) if_valid_n = 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_valid) begin
            pc_n = pc_plus4;
            if (!if_valid || !stall) begin
              if_valid_n = 1'b1;
              if_instr_n = imem_rdata;
              if_pc4_n   = pc_plus4;
            end else begin
              skid_instr_n = imem_rdata;
              skid_pc4_n   = pc_plus4;
              state_n      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_n = 1'b1;
            if_instr_n = skid_instr;
            if_pc4_n   = skid_pc4;
            state_n    = FETCH;
          end
        end
        DRAIN: begin
          if (imem_valid) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_taken;
  assign fetch_taken = imem_valid && !redirect && (state == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (fetch_taken && (perf_fetches != '1))
        perf_fetches <= perf_fetches + PERF_W'(1);
      if (if_valid && stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed and randomised bench for instr_fetch_stage with a queue-based model
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic [5:0]  instr_op;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetches;
  logic [15:0] perf_stall_cycles;
`endif

  instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4), .instr_op(instr_op)
`ifdef FETCH_PERF_EN
    , .perf_fetches(perf_fetches), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'h0000_0020;
      32'hFFFF_FFFC: return 32'hFC00_0001;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Model: a FIFO of at most two fetched words (IF/ID + skid); requests stop when it is full.
  typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} ent_t;
  ent_t        m_q[$];
  ent_t        m_stale = '0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_drain = 1'b0;
  bit          m_fetching;
  int unsigned m_fetches = 0;
  int unsigned m_stalls = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete();
      m_stale   = '0;
      m_pc      = RESET_PC;
      m_drain   = 1'b0;
      m_fetches = 0;
      m_stalls  = 0;
    end else begin
      m_fetching = !m_drain && (m_q.size() < 2);
      if (m_q.size() > 0 && stall && m_stalls < 65535) m_stalls++;
      if (redirect) begin
        m_drain = (m_fetching || m_drain) && !imem_valid;
        m_q.delete();
        m_stale = '0;
        m_pc    = redirect_pc;
      end else begin
        if (m_q.size() > 0 && !stall) m_stale = m_q.pop_front();
        if (imem_valid) begin
          if (m_drain) m_drain = 1'b0;
          else begin
            m_q.push_back('{instr: imem_rdata, pc4: m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
            if (m_fetches < 65535) m_fetches++;
          end
        end
      end
    end
  end

  logic exp_req;
  ent_t head;
  initial forever begin
    @(negedge clk);
    exp_req = (rst !== 1'b1) && !m_drain && (m_q.size() < 2);
    head    = (m_q.size() > 0) ? m_q[0] : m_stale;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
    chk("if_instr", if_instr, head.instr);
    chk("if_pc_plus4", if_pc_plus4, head.pc4);
    chk("instr_op", 32'(instr_op), 32'(head.instr[31:26]));
`ifdef FETCH_PERF_EN
    chk("perf_fetches", 32'(perf_fetches), 32'(m_fetches));
    chk("perf_stall_cycles", 32'(perf_stall_cycles), 32'(m_stalls));
`endif
  end

  // Memory: accepts one request, answers lat cycles later counting the request cycle.
  int          lat = 1;
  int          cnt = 0;
  bit          pending = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] req_log[$];

  task automatic tick();
    @(negedge clk);
    #1;
    imem_valid = 1'b0;
    if (rst) pending = 1'b0;
    else begin
      if (!pending && imem_req) begin
        pending = 1'b1;
        paddr   = imem_addr;
        cnt     = lat - 1;
        req_log.push_back(imem_addr);
      end
      if (pending) begin
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(paddr);
          pending    = 1'b0;
        end else cnt--;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_after_rst", 32'(imem_req), 32'd1);
    chk("addr_after_rst", imem_addr, RESET_PC);

    n = 0;
    do begin tick(); n++; end while (!if_valid && n < 20);
    chk("first_instr", if_instr, 32'h8C01_0004);
    chk("first_op", 32'(instr_op), 32'h23);
    chk("first_pc4", if_pc_plus4, 32'd4);
    stall = 1'b1;
    tick();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_instr", if_instr, 32'h8C01_0004);
    tick(); tick();
    stall = 1'b0;
    tick();
    chk("skid_instr", if_instr, 32'h0000_0020);
    chk("skid_op", 32'(instr_op), 32'd0);
    chk("skid_pc4", if_pc_plus4, 32'd8);
    chk("refetch_addr", imem_addr, 32'd8);
    chk("req_log_len", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 3) begin
      chk("req_log0", req_log[0], 32'd0);
      chk("req_log1", req_log[1], 32'd4);
      chk("req_log2", req_log[2], 32'd8);
    end

    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("redir_if_valid", 32'(if_valid), 32'd0);
    chk("redir_op", 32'(instr_op), 32'd0);
    chk("drain_req", 32'(imem_req), 32'd0);
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_no_valid", 32'(if_valid), 32'd0);

    n = 0;
    while (!imem_valid && n < 20) begin tick(); n++; end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("same_cyc_valid", 32'(if_valid), 32'd0);
    chk("same_cyc_req", 32'(imem_req), 32'd1);
    chk("same_cyc_addr", imem_addr, 32'h0000_0100);

    lat = 1;
    n = 0;
    do begin tick(); n++; end while (!if_valid && n < 20);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    chk("wrap_instr", if_instr, 32'hFC00_0001);
    chk("wrap_pc4", if_pc_plus4, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    stall = 1'b1;
    n = 0;
    while (imem_req && n < 20) begin tick(); n++; end
    chk("pre_rst_hold", 32'(if_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(if_valid), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", imem_addr, RESET_PC);
    chk("async_rst_instr", if_instr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("async_rst_perf_f", 32'(perf_fetches), 32'd0);
    chk("async_rst_perf_s", 32'(perf_stall_cycles), 32'd0);
`endif
    tick(); tick();
    rst = 1'b0; stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      tick();
      stall    = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 12) == 0);
      redirect_pc = $urandom;
      lat = $urandom_range(1, 3);
    end
    redirect = 1'b0; stall = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
